// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared types and helpers for the Bulls & Cows game
package bc_pkg;

   // Game phase, also decoded by the display manager
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SECRET_J1 = 3'd1,
      SECRET_J2 = 3'd2,
      GUESS_J1  = 3'd3,
      GUESS_J2  = 3'd4,
      WIN       = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_J1   = 2'b01,
      WIN_J2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   typedef logic [3:0] digit_t;
   // Element [3] is the leftmost digit (entry[15:12])
   typedef digit_t [3:0] code_t;

   localparam logic [2:0] ALL_BULLS = 3'd4;

   // Increment that sticks at 255
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/bc_scorer.sv
// rtl/bc_scorer.sv - combinational entry validation and bulls/cows scoring
module bc_scorer
   import bc_pkg::*;
(
   input  code_t      guess,
   input  code_t      secret,
   output logic       valid,
   output logic [2:0] bulls,
   output logic [2:0] cows
);

   // Validity looks at the guess alone; score compares every digit pair
   always_comb begin
      valid = 1'b1;
      bulls = 3'd0;
      cows  = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (guess[i] > 4'd9) begin
            valid = 1'b0;
         end
         for (int j = 0; j < 4; j++) begin
            if (i != j && guess[i] == guess[j]) begin
               valid = 1'b0;
            end
            if (guess[i] == secret[j]) begin
               if (i == j) begin
                  bulls = bulls + 3'd1;
               end else begin
                  cows = cows + 3'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/bc_game_controller.sv
// rtl/bc_game_controller.sv - Bulls & Cows game sequencer
module bc_game_controller
   import bc_pkg::*;
#(
   parameter int MAX_ATTEMPTS = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        confirm,
   input  logic [15:0] entry,
   output logic [2:0]  phase,
   output logic [2:0]  bulls,
   output logic [2:0]  cows,
   output logic        result_valid,
   output logic        err_invalid,
   output logic [1:0]  winner,
   output logic [7:0]  attempts_j1,
   output logic [7:0]  attempts_j2
);

   state_t      state_q, state_d;
   logic        btn_prev_q, btn_prev_d;
   logic        tick_q, tick_d;
   code_t       secret1_q, secret1_d;
   code_t       secret2_q, secret2_d;
   logic [2:0]  bulls_q, bulls_d;
   logic [2:0]  cows_q, cows_d;
   logic        result_valid_q, result_valid_d;
   logic        err_invalid_q, err_invalid_d;
   winner_t     winner_q, winner_d;
   logic [7:0]  att1_q, att1_d;
   logic [7:0]  att2_q, att2_d;

   code_t       entry_code;
   code_t       opp_secret;
   logic        entry_valid;
   logic [2:0]  score_bulls;
   logic [2:0]  score_cows;
   logic [7:0]  att2_inc;

   assign entry_code = entry;
   // J1 guesses against J2's secret, everyone else against J1's
   assign opp_secret = (state_q == GUESS_J1) ? secret2_q : secret1_q;
   assign att2_inc   = sat_inc8(att2_q);

   bc_scorer u_scorer (
      .guess  (entry_code),
      .secret (opp_secret),
      .valid  (entry_valid),
      .bulls  (score_bulls),
      .cows   (score_cows)
   );

   // Rising-edge detector on the already synchronised button
   always_comb begin
      btn_prev_d = confirm;
      tick_d     = confirm & ~btn_prev_q;
   end

   // Game FSM: acts only on the registered tick
   always_comb begin
      state_d        = state_q;
      secret1_d      = secret1_q;
      secret2_d      = secret2_q;
      bulls_d        = bulls_q;
      cows_d         = cows_q;
      winner_d       = winner_q;
      att1_d         = att1_q;
      att2_d         = att2_q;
      result_valid_d = 1'b0;
      err_invalid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick_q) begin
               state_d = SECRET_J1;
            end
         end
         SECRET_J1: begin
            if (tick_q) begin
               if (entry_valid) begin
                  secret1_d = entry_code;
                  state_d   = SECRET_J2;
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         SECRET_J2: begin
            if (tick_q) begin
               if (entry_valid) begin
                  secret2_d = entry_code;
                  state_d   = GUESS_J1;
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         GUESS_J1: begin
            if (tick_q) begin
               if (entry_valid) begin
                  bulls_d        = score_bulls;
                  cows_d         = score_cows;
                  att1_d         = sat_inc8(att1_q);
                  result_valid_d = 1'b1;
                  if (score_bulls == ALL_BULLS) begin
                     state_d  = WIN;
                     winner_d = WIN_J1;
                  end else begin
                     state_d = GUESS_J2;
                  end
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         GUESS_J2: begin
            if (tick_q) begin
               if (entry_valid) begin
                  bulls_d        = score_bulls;
                  cows_d         = score_cows;
                  att2_d         = att2_inc;
                  result_valid_d = 1'b1;
                  if (score_bulls == ALL_BULLS) begin
                     state_d  = WIN;
                     winner_d = WIN_J2;
                  end else if (att2_inc == 8'(MAX_ATTEMPTS)) begin
                     state_d  = WIN;
                     winner_d = WIN_DRAW;
                  end else begin
                     state_d = GUESS_J1;
                  end
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         WIN: begin
            if (tick_q) begin
               secret1_d = '0;
               secret2_d = '0;
               bulls_d   = 3'd0;
               cows_d    = 3'd0;
               att1_d    = 8'd0;
               att2_d    = 8'd0;
               winner_d  = WIN_NONE;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; btn_prev resets high so a held button cannot fire
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         btn_prev_q     <= 1'b1;
         tick_q         <= 1'b0;
         secret1_q      <= '0;
         secret2_q      <= '0;
         bulls_q        <= 3'd0;
         cows_q         <= 3'd0;
         result_valid_q <= 1'b0;
         err_invalid_q  <= 1'b0;
         winner_q       <= WIN_NONE;
         att1_q         <= 8'd0;
         att2_q         <= 8'd0;
      end else begin
         state_q        <= state_d;
         btn_prev_q     <= btn_prev_d;
         tick_q         <= tick_d;
         secret1_q      <= secret1_d;
         secret2_q      <= secret2_d;
         bulls_q        <= bulls_d;
         cows_q         <= cows_d;
         result_valid_q <= result_valid_d;
         err_invalid_q  <= err_invalid_d;
         winner_q       <= winner_d;
         att1_q         <= att1_d;
         att2_q         <= att2_d;
      end
   end

   assign phase        = state_q;
   assign bulls        = bulls_q;
   assign cows         = cows_q;
   assign result_valid = result_valid_q;
   assign err_invalid  = err_invalid_q;
   assign winner       = winner_q;
   assign attempts_j1  = att1_q;
   assign attempts_j2  = att2_q;

endmodule

// File: tb/tb_bc_game_controller.sv
// tb/tb_bc_game_controller.sv - scoreboard bench for bc_game_controller
module tb_bc_game_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        confirm;
   logic [15:0] entry;
   logic [2:0]  phase;
   logic [2:0]  bulls;
   logic [2:0]  cows;
   logic        result_valid;
   logic        err_invalid;
   logic [1:0]  winner;
   logic [7:0]  attempts_j1;
   logic [7:0]  attempts_j2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         is_err;
      logic [2:0] b;
      logic [2:0] c;
   } exp_t;

   exp_t sb_q[$];

   bc_game_controller #(.MAX_ATTEMPTS(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .confirm      (confirm),
      .entry        (entry),
      .phase        (phase),
      .bulls        (bulls),
      .cows         (cows),
      .result_valid (result_valid),
      .err_invalid  (err_invalid),
      .winner       (winner),
      .attempts_j1  (attempts_j1),
      .attempts_j2  (attempts_j2)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_score(input logic [2:0] b, input logic [2:0] c);
      exp_t e;
      e.is_err = 1'b0;
      e.b = b;
      e.c = c;
      sb_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.b = 3'd0;
      e.c = 3'd0;
      sb_q.push_back(e);
   endtask

   task automatic press(input logic [15:0] e);
      @(negedge clock);
      entry   = e;
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Monitor: every output pulse must match the oldest expectation
   always @(negedge clock) begin : monitor
      exp_t e;
      bit   ok;
      if (result_valid || err_invalid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got rv=%0d err=%0d expected no pulse", result_valid, err_invalid);
         end else begin
            e = sb_q.pop_front();
            if (e.is_err) ok = err_invalid && !result_valid;
            else ok = result_valid && !err_invalid && bulls == e.b && cows == e.c;
            if (!ok) begin
               errors++;
               $display("FAIL pulse_match: got rv=%0d err=%0d bulls=%0d cows=%0d expected err=%0d bulls=%0d cows=%0d",
                        result_valid, err_invalid, bulls, cows, e.is_err, e.b, e.c);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      confirm = 1'b1;
      entry   = 16'h0000;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (20) @(negedge clock);
      check("held_phase", phase, 0);
      check("rst_winner", winner, 0);
      check("rst_bulls", bulls, 0);
      check("rst_cows", cows, 0);
      check("rst_att1", attempts_j1, 0);
      check("rst_att2", attempts_j2, 0);
      confirm = 1'b0;
      repeat (2) @(negedge clock);

      // Latency: phase moves on the second edge after confirm rises
      confirm = 1'b1;
      @(posedge clock); #1;
      check("lat_first_edge", phase, 0);
      @(posedge clock); #1;
      check("lat_second_edge", phase, 1);
      @(negedge clock);
      confirm = 1'b0;
      repeat (2) @(negedge clock);

      // Secret entry with rejections
      push_err(); press(16'h1123);
      check("rep_phase", phase, 1);
      push_err(); press(16'h12A4);
      check("gt9_phase", phase, 1);
      press(16'h1234);
      check("s1_phase", phase, 2);
      press(16'h5678);
      check("s2_phase", phase, 3);
      check("s2_bulls", bulls, 0);

      // Game one: J1 wins on its second guess
      push_score(3'd0, 3'd4); press(16'h8765);
      check("g1_phase", phase, 4);
      check("g1_att1", attempts_j1, 1);
      check("g1_att2", attempts_j2, 0);
      push_score(3'd2, 3'd2); press(16'h1243);
      check("g2_phase", phase, 3);
      check("g2_att2", attempts_j2, 1);
      push_err(); press(16'h9999);
      check("bad_guess_phase", phase, 3);
      check("bad_guess_att1", attempts_j1, 1);
      check("bad_guess_bulls", bulls, 2);
      push_score(3'd4, 3'd0); press(16'h5678);
      check("win_phase", phase, 5);
      check("win_winner", winner, 1);
      check("win_att1", attempts_j1, 2);
      press(16'h1123);
      check("clr_phase", phase, 0);
      check("clr_winner", winner, 0);
      check("clr_att1", attempts_j1, 0);
      check("clr_att2", attempts_j2, 0);
      check("clr_bulls", bulls, 0);
      check("clr_cows", cows, 0);

      // Game two: draw after both players use MAX_ATTEMPTS=2
      press(16'h0000);
      press(16'h1234);
      press(16'h5678);
      push_score(3'd2, 3'd2); press(16'h5687);
      push_score(3'd2, 3'd2); press(16'h1243);
      check("d2_phase", phase, 3);
      push_score(3'd0, 3'd4); press(16'h8765);
      push_score(3'd0, 3'd4); press(16'h4321);
      check("draw_phase", phase, 5);
      check("draw_winner", winner, 3);
      check("draw_att1", attempts_j1, 2);
      check("draw_att2", attempts_j2, 2);
      press(16'h0000);
      check("draw_clr_phase", phase, 0);

      // Game three: reset lands while J2's winning press is in flight
      press(16'h0000);
      press(16'h1234);
      press(16'h5678);
      push_score(3'd0, 3'd4); press(16'h8765);
      check("pre_rst_phase", phase, 4);
      @(negedge clock);
      entry   = 16'h1234;
      confirm = 1'b1;
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      check("async_phase", phase, 0);
      check("async_bulls", bulls, 0);
      check("async_cows", cows, 0);
      check("async_rv", result_valid, 0);
      check("async_att1", attempts_j1, 0);
      check("async_winner", winner, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         confirm = ~confirm;
      end
      @(negedge clock);
      confirm = 1'b0;
      reset   = 1'b1;
      repeat (5) @(negedge clock);
      check("post_rst_phase", phase, 0);
      check("post_rst_att1", attempts_j1, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
